// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the game-session controller.
//   state_t : session state encoding, also driven out on the 2-bit state port
//   max_u   : elaboration-time helper for sizing counters
package game_state_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_ATTRACT  = 2'b00,
        ST_PLAYING  = 2'b01,
        ST_INVULN   = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_state_ctrl_frame_timer.sv
// Frame-granular down-counter shared by the INVULN and GAME_OVER phases.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   enable      : decrement strobe (one per frame)
//   load        : load load_value; takes priority over the decrement
//   load_value  : value to load
//   count       : current count, stops at zero
//   done        : count is zero
module game_state_ctrl_frame_timer #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/game_state_ctrl.sv
// Game-session controller: attract / playing / invulnerable / game-over FSM with
// scoring, lives, level and speed derivation, all in the pixel-clock domain.
// Ports:
//   clk, reset     : pixel clock, asynchronous active-high reset
//   vsync          : frame sync, synchronous to clk; its rising edge starts a frame
//   start          : restart button (level)
//   star_alive     : per-star alive flags; a 1->0 fall is a collection
//   meteor_hit     : per-meteor ship collision flags
//   frame_tick     : one-clk pulse per frame; all session updates happen on it
//   state          : session state (see game_state_ctrl_pkg::state_t)
//   score, lives   : session score (saturating) and remaining lives
//   level, speed   : difficulty derived from score, one and two clks behind it
//   ship_blink     : suppress the ship pixel while invulnerable
//   clear_objects  : one-clk pulse at game start to respawn all objects
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STARS       = 2,
    parameter int unsigned NUM_METEORS     = 3,
    parameter int unsigned MAX_LIVES       = 3,
    parameter int unsigned LIVES_W         = 2,
    parameter int unsigned SCORE_W         = 4,
    parameter int unsigned SCORE_MAX       = 9,
    parameter int unsigned LEVEL_STEP      = 3,
    parameter int unsigned MAX_LEVEL       = 3,
    parameter int unsigned SPEED_BASE      = 15,
    parameter int unsigned SPEED_STEP      = 4,
    parameter int unsigned SPEED_W         = 5,
    parameter int unsigned INVULN_FRAMES   = 60,
    parameter int unsigned GAMEOVER_FRAMES = 120
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   start,
    input  logic [NUM_STARS-1:0]   star_alive,
    input  logic [NUM_METEORS-1:0] meteor_hit,
    output logic                   frame_tick,
    output logic [1:0]             state,
    output logic [SCORE_W-1:0]     score,
    output logic [LIVES_W-1:0]     lives,
    output logic [1:0]             level,
    output logic [SPEED_W-1:0]     speed,
    output logic                   ship_blink,
    output logic                   clear_objects
);

    localparam int unsigned TIMER_MAX = max_u(INVULN_FRAMES, GAMEOVER_FRAMES);
    // At least 3 bits so the blink tap (bit 2) always exists.
    localparam int unsigned TIMER_W   = max_u($clog2(TIMER_MAX + 1), 3);
    localparam int unsigned CNT_W     = max_u($clog2(NUM_STARS + 1), 1);
    localparam int unsigned SPEED_SAT = (1 << SPEED_W) - 1;

    // Registered state
    logic                 vsync_d_q;
    logic                 frame_tick_q;
    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [NUM_STARS-1:0] star_prev_q, star_prev_d;
    logic                 clear_q, clear_d;
    logic [1:0]           level_q, level_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;

    // Shared frame timer
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_load_val;
    logic [TIMER_W-1:0]   tmr_count;
    logic                 tmr_done;

    game_state_ctrl_frame_timer #(
        .WIDTH (TIMER_W)
    ) u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (frame_tick_q),
        .load       (tmr_load),
        .load_value (tmr_load_val),
        .count      (tmr_count),
        .done       (tmr_done)
    );

    // Collections this frame: popcount of falling alive flags, as an adder chain.
    logic [NUM_STARS-1:0] star_edge;
    logic [CNT_W-1:0]     collected;

    assign star_edge = star_prev_q & ~star_alive;

    for (genvar i = 0; i < NUM_STARS; i++) begin : g_pop
        logic [CNT_W-1:0] acc;
        if (i == 0) begin : g_head
            assign acc = CNT_W'(star_edge[0]);
        end else begin : g_tail
            assign acc = g_pop[i-1].acc + CNT_W'(star_edge[i]);
        end
    end

    assign collected = g_pop[NUM_STARS-1].acc;

    logic [31:0]        score_sum;
    logic [SCORE_W-1:0] score_sat;

    assign score_sum = 32'(score_q) + 32'(collected);
    assign score_sat = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];

    // Level thresholds: lvl_ge[j] means score reached level j+1.
    logic [MAX_LEVEL-1:0] lvl_ge;

    for (genvar i = 0; i < MAX_LEVEL; i++) begin : g_lvl
        assign lvl_ge[i] = (32'(score_q) >= (i + 1) * LEVEL_STEP);
    end

    always_comb begin
        level_d = 2'd0;
        for (int unsigned j = 0; j < MAX_LEVEL; j++) begin
            if (lvl_ge[j]) begin
                level_d = 2'(j + 1);
            end
        end
    end

    logic [31:0] speed_sum;

    assign speed_sum = SPEED_BASE + 32'(level_q) * SPEED_STEP;
    assign speed_d   = (speed_sum > SPEED_SAT) ? SPEED_W'(SPEED_SAT) : speed_sum[SPEED_W-1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d_q    <= 1'b1;  // high so a vsync already high after reset is not an edge
            frame_tick_q <= 1'b0;
            state_q      <= ST_ATTRACT;
            score_q      <= '0;
            lives_q      <= LIVES_W'(MAX_LIVES);
            star_prev_q  <= '1;
            clear_q      <= 1'b0;
            level_q      <= 2'd0;
            speed_q      <= SPEED_W'(SPEED_BASE);
        end else begin
            vsync_d_q    <= vsync;
            frame_tick_q <= vsync & ~vsync_d_q;
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            star_prev_q  <= star_prev_d;
            clear_q      <= clear_d;
            level_q      <= level_d;
            speed_q      <= speed_d;
        end
    end

    // Next-state logic; everything advances only on the frame tick.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        star_prev_d  = star_prev_q;
        clear_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        if (frame_tick_q) begin
            star_prev_d = star_alive;
            unique case (state_q)
                ST_ATTRACT: begin
                    if (start) begin
                        clear_d     = 1'b1;
                        score_d     = '0;
                        lives_d     = LIVES_W'(MAX_LIVES);
                        star_prev_d = '1;
                        state_d     = ST_PLAYING;
                    end
                end
                ST_PLAYING: begin
                    score_d = score_sat;
                    if (|meteor_hit) begin
                        tmr_load = 1'b1;
                        if (lives_q <= LIVES_W'(1)) begin
                            lives_d      = '0;
                            tmr_load_val = TIMER_W'(GAMEOVER_FRAMES);
                            state_d      = ST_GAMEOVER;
                        end else begin
                            lives_d      = lives_q - LIVES_W'(1);
                            tmr_load_val = TIMER_W'(INVULN_FRAMES);
                            state_d      = ST_INVULN;
                        end
                    end
                end
                ST_INVULN: begin
                    score_d = score_sat;
                    if (tmr_count == TIMER_W'(1)) begin
                        state_d = ST_PLAYING;
                    end
                end
                ST_GAMEOVER: begin
                    if (tmr_done && start) begin
                        clear_d     = 1'b1;
                        score_d     = '0;
                        lives_d     = LIVES_W'(MAX_LIVES);
                        star_prev_d = '1;
                        state_d     = ST_PLAYING;
                    end
                end
                default: begin
                    state_d = ST_ATTRACT;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        state         = state_q;
        ship_blink    = (state_q == ST_INVULN) && tmr_count[2];
        frame_tick    = frame_tick_q;
        clear_objects = clear_q;
        score         = score_q;
        lives         = lives_q;
        level         = level_q;
        speed         = speed_q;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised game-session controller for the VGA shooter. It replaces the fixed 2-star/3-meteor score and lives logic, which was clocked directly on vsync, with a single-clock-domain FSM. Adds ATTRACT, PLAYING, INVULN and GAME_OVER states, restart on a button, post-hit invulnerability with ship blink, multi-hit-per-frame scoring, and level/speed derivation. Sits between the object modules (meteors, stars, bullet, collision detection) and the HUD/colour logic of the top level.

Parameters:
NUM_STARS, 2, number of collectible star channels
NUM_METEORS, 3, number of meteor hit inputs
MAX_LIVES, 3, lives loaded at game start (must fit LIVES_W)
LIVES_W, 2, lives output width
SCORE_W, 4, score output width
SCORE_MAX, 9, score saturation value
LEVEL_STEP, 3, points per level
MAX_LEVEL, 3, level saturation value
SPEED_BASE, 15, speed at level 0
SPEED_STEP, 4, speed increment per level
SPEED_W, 5, speed width; speed saturates at 2^SPEED_W-1
INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit
GAMEOVER_FRAMES, 120, frames before restart is accepted

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
vsync  in  1  vsync from hvsync_generator, synchronous to clk
start  in  1  restart button, level-sensitive
star_alive  in  NUM_STARS  per-star alive flags; a 1->0 transition is a collection
meteor_hit  in  NUM_METEORS  per-meteor collision with ship, level
frame_tick  out  1  one-clk pulse per frame
state  out  2  00 ATTRACT, 01 PLAYING, 10 INVULN, 11 GAME_OVER
score  out  SCORE_W  current score
lives  out  LIVES_W  remaining lives
level  out  2  current level (0..MAX_LEVEL)
speed  out  SPEED_W  object speed for meteor module
ship_blink  out  1  1 = suppress ship pixel this frame
clear_objects  out  1  one-clk pulse at game start; respawns all objects

Behaviour:
- Reset (async, active-high) values: state ATTRACT, score 0, lives MAX_LIVES, level 0, speed SPEED_BASE, frame_tick 0, ship_blink 0, clear_objects 0, internal vsync_d 1, star_prev all 1, timer 0.
- frame_tick = vsync & ~vsync_d, registered; exactly one clk wide. All state updates below occur only on the clk edge where frame_tick is high.
- Star edges: star_prev is updated every tick in every state. k = popcount(star_prev & ~star_alive).
- ATTRACT: if start, pulse clear_objects for 1 clk; load score 0, lives MAX_LIVES, star_prev all 1; go to PLAYING.
- PLAYING: score += k, saturating at SCORE_MAX.
  - If |meteor_hit, lives decrements by exactly 1, regardless of how many bits are set.
  - If lives was 1: go to GAME_OVER, timer = GAMEOVER_FRAMES, lives = 0.
  - Otherwise: go to INVULN, timer = INVULN_FRAMES.
  - Score and hit in the same tick both apply; the score is added even when the hit is fatal.
- INVULN: meteor_hit is ignored; scoring continues. Timer decrements per tick. On the tick where timer==1, go to PLAYING. ship_blink = timer[2].
- GAME_OVER: score and lives frozen; timer decrements to 0. start is ignored while timer != 0. With timer == 0 and start: same initialisation as ATTRACT, then PLAYING.
- start held through the transition does not retrigger, because PLAYING ignores start.
- level: registered; equals the largest i <= MAX_LEVEL with score >= i*LEVEL_STEP; built as a comparator chain, no divider. Updates 1 clk after score.
- speed: registered; min(SPEED_BASE + level*SPEED_STEP, 2^SPEED_W-1). Updates 1 clk after level.
- Reset asserted mid-game: immediate return to reset values. No tick is generated until a new vsync rising edge.
- Score saturation: collections still clear star_prev but do not change score.

Decomposition:
- Shared package: state encoding constants (ST_ATTRACT, ST_PLAYING, ST_INVULN, ST_GAMEOVER).
- Sub-module frame_timer: down-counter with load, enable = frame_tick, done flag. Instantiated once and reused for the INVULN and GAME_OVER timers.
- Popcount and level comparator chain are generate loops inside the top.

Test Plan:
- Reset, 3 vsync pulses, start=0 -> state 00, score 0, lives 3, speed 15, one frame_tick per vsync rise.
- start=1 for 1 frame -> clear_objects 1 clk, state 01. Then both star_alive bits fall in the same frame -> score 2 after that tick.
- Score 2 -> 3 -> level 1 one clk later, speed 19 one clk after that. Score driven to 12 collections -> score holds 9, level 3, speed 27.
- meteor_hit=3'b101 for 5 frames in PLAYING with lives 3 -> lives 2 (single decrement), state 10, ship_blink toggles every 4 frames, state 01 after 60 ticks.
- Lives 1 plus a star edge and a hit in the same tick -> score +1, lives 0, state 11. start held -> no restart for 120 ticks, then restart with score 0, lives 3.
- Assert reset in INVULN mid-frame -> all outputs return to reset values asynchronously, with no frame_tick until the next vsync rising edge.
